// File: rtl/mux_scheduler.sv
// mux_scheduler: three-source time-slice / priority multiplexer with a
// one-word registered output buffer.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   DS1..DS3, ds1..3_valid      source words and their valid flags
//   ds1..3_ready                per-source accept flags (combinational)
//   mode                        00 off, 01 round-robin, 10 fixed priority, 11 hold
//   switch_clk_cycles           slot length N (0 behaves as 1)
//   output_data, out_valid      registered selected word and its valid flag
//   out_ready                   downstream accept
//   sel                         granted source, 0 = none, 1..3 = DS1..DS3
//   dbg_state_o                 FSM state (0 IDLE, 1 SERVE)
//
// Handshake: a word moves on a rising edge where valid and ready are both 1.
// Upstream ready never depends on the same source's valid; it depends only
// on state, sel, mode and whether the output buffer can take a word.
module mux_scheduler #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] DS1,
  input  logic [DATA_W-1:0] DS2,
  input  logic [DATA_W-1:0] DS3,
  input  logic              ds1_valid,
  input  logic              ds2_valid,
  input  logic              ds3_valid,
  output logic              ds1_ready,
  output logic              ds2_ready,
  output logic              ds3_ready,
  input  logic [1:0]        mode,
  input  logic [3:0]        switch_clk_cycles,
  output logic [DATA_W-1:0] output_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        sel,
  output logic              dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        n_q, n_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        mode_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [2:0]        valid_v;
  logic              any_valid;
  logic              grant;
  logic              xfer;
  logic              do_pick;
  logic [1:0]        pick;
  logic [3:0]        n_eff;
  logic [DATA_W-1:0] sel_data;

  // First valid source after 'last' in circular order 1->2->3->1, so the
  // last-served source has the lowest priority.
  function automatic logic [1:0] pick_rr(input logic [1:0] last, input logic [2:0] v);
    logic [1:0] r;
    r = 2'd0;
    case (last)
      2'd1: r = v[1] ? 2'd2 : v[2] ? 2'd3 : v[0] ? 2'd1 : 2'd0;
      2'd2: r = v[2] ? 2'd3 : v[0] ? 2'd1 : v[1] ? 2'd2 : 2'd0;
      default: r = v[0] ? 2'd1 : v[1] ? 2'd2 : v[2] ? 2'd3 : 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] pick_fix(input logic [2:0] v);
    return v[0] ? 2'd1 : v[1] ? 2'd2 : v[2] ? 2'd3 : 2'd0;
  endfunction

  always_comb begin
    valid_v   = {ds3_valid, ds2_valid, ds1_valid};
    any_valid = |valid_v;
    // Buffer can take a word if empty or being drained this edge.
    grant     = (state_q == SERVE) && (mode != 2'b00) && (!out_valid_q || out_ready);
    ds1_ready = grant && (sel_q == 2'd1);
    ds2_ready = grant && (sel_q == 2'd2);
    ds3_ready = grant && (sel_q == 2'd3);
    xfer      = (ds1_ready && ds1_valid) || (ds2_ready && ds2_valid) ||
                (ds3_ready && ds3_valid);
    case (sel_q)
      2'd1:    sel_data = DS1;
      2'd2:    sel_data = DS2;
      2'd3:    sel_data = DS3;
      default: sel_data = '0;
    endcase
    n_eff = (switch_clk_cycles == 4'd0) ? 4'd1 : switch_clk_cycles;
    pick  = (mode == 2'b01) ? pick_rr(rr_q, valid_v) : pick_fix(valid_v);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    rr_d    = rr_q;
    do_pick = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode != 2'b00 && any_valid) do_pick = 1'b1;
      end
      SERVE: begin
        if (mode == 2'b00) begin
          state_d = IDLE;
          sel_d   = 2'd0;
          cnt_d   = 4'd0;
        end else if (mode != mode_q) begin
          // Policy changed between two active modes: close the slot now.
          do_pick = 1'b1;
        end else if (mode != 2'b11) begin
          if (cnt_q == n_q - 4'd1) do_pick = 1'b1;
          else                     cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
      end
    endcase
    if (do_pick) begin
      cnt_d = 4'd0;
      if (any_valid) begin
        state_d = SERVE;
        sel_d   = pick;
        rr_d    = pick;
        n_d     = n_eff;
      end else begin
        state_d = IDLE;
        sel_d   = 2'd0;
      end
    end
  end

  // Output buffer: a transfer always loads (the word is from the source that
  // was granted before this edge); otherwise a downstream accept empties it.
  always_comb begin
    data_d      = data_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      data_d      = sel_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      cnt_q       <= 4'd0;
      n_q         <= 4'd1;
      rr_q        <= 2'd3;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      rr_q        <= rr_d;
      mode_q      <= mode;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign output_data = data_q;
  assign out_valid   = out_valid_q;
  assign sel         = sel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_scheduler.sv
module tb_mux_scheduler;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] DS1, DS2, DS3;
  logic         ds1_valid, ds2_valid, ds3_valid;
  logic         ds1_ready, ds2_ready, ds3_ready;
  logic [1:0]   mode;
  logic [3:0]   switch_clk_cycles;
  logic [W-1:0] output_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   sel;
  logic         dbg_state;
  logic [2:0]   rdy;

  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  mux_scheduler #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .DS1(DS1), .DS2(DS2), .DS3(DS3),
    .ds1_valid(ds1_valid), .ds2_valid(ds2_valid), .ds3_valid(ds3_valid),
    .ds1_ready(ds1_ready), .ds2_ready(ds2_ready), .ds3_ready(ds3_ready),
    .mode(mode), .switch_clk_cycles(switch_clk_cycles),
    .output_data(output_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .dbg_state_o(dbg_state)
  );

  assign rdy = {ds3_ready, ds2_ready, ds1_ready};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic v1, input logic v2, input logic v3);
    ds1_valid = v1;
    ds2_valid = v2;
    ds3_valid = v3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode = 2'b00;
    switch_clk_cycles = 4'd0;
    set_valid(1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push_n(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  // scoreboard monitor: a word is consumed where out_valid && out_ready
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL out_word: got %0h expected none at %0t", output_data, $time);
      end else begin
        chk("out_word", output_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    DS1 = 8'h00; DS2 = 8'h00; DS3 = 8'h00;
    do_reset();
    // reset state
    chk("rst_sel", sel, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", output_data, 0);
    chk("rst_ready", rdy, 0);

    // round-robin, N=6, all sources valid
    DS1 = 8'hAA; DS2 = 8'hBB; DS3 = 8'hCC;
    mode = 2'b01; switch_clk_cycles = 4'd6;
    set_valid(1'b1, 1'b1, 1'b1);
    push_n(8'hAA, 6); push_n(8'hBB, 6); push_n(8'hCC, 6);
    #1 chk("rr_idle_ready", rdy, 0);
    for (int k = 0; k <= 18; k++) begin
      step();
      chk("rr_sel", sel, 32'(1 + (k / 6) % 3));
      if (k == 0) chk("rr_first_ovalid", out_valid, 0);
      if (k == 1) chk("rr_first_data", output_data, 32'hAA);
    end
    set_valid(1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rr_drained", out_valid, 0);

    // fixed priority, N=3, DS1 joins later
    do_reset();
    DS1 = 8'h11; DS2 = 8'hBB; DS3 = 8'hCC;
    mode = 2'b10; switch_clk_cycles = 4'd3;
    set_valid(1'b0, 1'b1, 1'b1);
    push_n(8'hBB, 9);
    for (int k = 0; k <= 6; k++) begin
      step();
      chk("fp_sel2", sel, 2);
    end
    ds1_valid = 1'b1;
    step(); chk("fp_sel_wait1", sel, 2);
    step(); chk("fp_sel_wait2", sel, 2);
    step(); chk("fp_sel1", sel, 1);
    set_valid(1'b0, 1'b0, 1'b0);
    step(); step();

    // output stall holds DD
    do_reset();
    DS1 = 8'hDD;
    mode = 2'b01; switch_clk_cycles = 4'd15;
    set_valid(1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    exp_q.push_back(8'hDD);
    exp_q.push_back(8'h44);
    step(); chk("stall_sel", sel, 1);
    step(); chk("stall_loaded", output_data, 32'hDD);
    DS1 = 8'h44;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_data", output_data, 32'hDD);
      chk("stall_ovalid", out_valid, 1);
      chk("stall_ready", rdy, 0);
    end
    out_ready = 1'b1;
    #1 chk("stall_release_ready", rdy, 3'b001);
    step(); chk("stall_next", output_data, 32'h44);
    set_valid(1'b0, 1'b0, 1'b0);
    step(); step();
    chk("stall_drained", out_valid, 0);

    // N=0 rotates every cycle, then mode off mid-slot
    do_reset();
    DS1 = 8'hAA; DS2 = 8'hBB; DS3 = 8'hCC;
    mode = 2'b01; switch_clk_cycles = 4'd0;
    set_valid(1'b1, 1'b1, 1'b1);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hAA);
    step(); chk("n0_sel_a", sel, 1);
    step(); chk("n0_sel_b", sel, 2);
    step(); chk("n0_sel_c", sel, 3);
    step(); chk("n0_sel_d", sel, 1);
    step(); chk("n0_sel_e", sel, 2);
    mode = 2'b00;
    #1 chk("off_ready_same_cycle", rdy, 0);
    step();
    chk("off_sel", sel, 0);
    chk("off_state", dbg_state, 0);
    chk("off_ovalid", out_valid, 0);
    set_valid(1'b0, 1'b0, 1'b0);
    step();

    // mode off with a buffered EE
    do_reset();
    DS1 = 8'hEE;
    mode = 2'b01; switch_clk_cycles = 4'd8;
    set_valid(1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    exp_q.push_back(8'hEE);
    step(); step();
    chk("ee_loaded", output_data, 32'hEE);
    mode = 2'b00;
    #1 chk("ee_off_ready", rdy, 0);
    step();
    chk("ee_sel", sel, 0);
    chk("ee_held", output_data, 32'hEE);
    chk("ee_held_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    step();
    chk("ee_drained", out_valid, 0);
    set_valid(1'b0, 1'b0, 1'b0);

    // reset mid-slot discards buffered word
    do_reset();
    DS1 = 8'hAA; DS2 = 8'hBB; DS3 = 8'hCC;
    mode = 2'b01; switch_clk_cycles = 4'd6;
    set_valid(1'b1, 1'b1, 1'b1);
    out_ready = 1'b0;
    step(); step();
    chk("mid_rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_data", output_data, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mid_rst_first", sel, 1);
    chk("mid_rst_ready", rdy, 3'b001);
    set_valid(1'b0, 1'b0, 1'b0);
    step(); step();

    // hold freezes sel; switching to round-robin re-picks at once
    do_reset();
    DS2 = 8'hBB; DS3 = 8'hCC;
    mode = 2'b11; switch_clk_cycles = 4'd1;
    set_valid(1'b0, 1'b1, 1'b1);
    push_n(8'hBB, 4);
    for (int k = 0; k <= 3; k++) begin
      step();
      chk("hold_sel", sel, 2);
    end
    mode = 2'b01;
    step(); chk("mode_chg_sel", sel, 3);
    set_valid(1'b0, 1'b0, 1'b0);
    step(); step();

    // final report
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
